// File: rtl/fpu_harness_pkg.sv
// fpu_harness_pkg
// Shared types and constants for the FPU vector harness.
//   state_e : harness FSM states
//   ERR_W   : width of the mismatch counter
//   sat_inc : saturating increment for the mismatch counter
package fpu_harness_pkg;

  localparam int ERR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    SEND,
    RECV,
    CHECK,
    DONE
  } state_e;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/harness_watchdog.sv
// harness_watchdog
// Stall watchdog for the vector harness. Only built when HARNESS_TIMEOUT_EN
// is defined; the file is empty otherwise.
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   active_i  : harness is in a state that waits on a handshake
//   kick_i    : a transfer happened this cycle
//   expire_o  : TIMEOUT consecutive active cycles without a transfer
`ifdef HARNESS_TIMEOUT_EN
module harness_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter: the cycle that finds it at zero is the TIMEOUT-th idle one.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (!active_i || kick_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q == '0) begin
      expire_o = 1'b1;
      cnt_d    = RELOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/fpu_vector_harness.sv
// fpu_vector_harness
// Streams test vectors from a synchronous vector memory into an FPU under
// test, collects each result and counts bitwise mismatches.
// Ports:
//   clk, rst, start                      : clock, sync reset, run pulse
//   vec_addr / vec_a, vec_b, vec_z       : vector memory (1-cycle read latency)
//   output_a*, output_b*                 : operand streams (stb/ack)
//   input_z*                             : result stream (stb/ack)
//   busy, done, pass, timeout            : run status
//   error_count, first_fail              : mismatch count, first failing index
// Optional feature: HARNESS_TIMEOUT_EN enables the stall watchdog; without it
// the harness waits forever on a handshake and timeout is tied low.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | vec_addr presents the current index
// WAIT_MEM | memory data valid, latched into operand/expected registers
// SEND     | operand strobes up until each stream has transferred
// RECV     | input_z_ack up until the result arrives
// CHECK    | compare result to expected, advance or finish
// DONE     | results held until next start
module fpu_vector_harness
  import fpu_harness_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    vec_addr,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [WIDTH-1:0] vec_z,
  output logic [WIDTH-1:0] output_a,
  output logic             output_a_stb,
  input  logic             output_a_ack,
  output logic [WIDTH-1:0] output_b,
  output logic             output_b_stb,
  input  logic             output_b_ack,
  input  logic [WIDTH-1:0] input_z,
  input  logic             input_z_stb,
  output logic             input_z_ack,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] error_count,
  output logic [AW-1:0]    first_fail
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > (1 << AW) || TIMEOUT < 1) begin : g_param_check
    $error("fpu_vector_harness: need 1 <= DEPTH <= 2**AW and TIMEOUT >= 1");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    index_q;
  logic [WIDTH-1:0] a_q, b_q, z_exp_q, z_got_q;
  logic             a_stb_q, b_stb_q;
  logic [ERR_W-1:0] err_q;
  logic [AW-1:0]    first_q;

  logic a_xfer, b_xfer, z_xfer, start_ok, err_evt, wd_expire;

  assign a_xfer   = a_stb_q & output_a_ack;
  assign b_xfer   = b_stb_q & output_b_ack;
  assign z_xfer   = (state_q == RECV) & input_z_stb;
  assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));
  assign err_evt  = ((state_q == CHECK) && (z_got_q != z_exp_q)) || wd_expire;

`ifdef HARNESS_TIMEOUT_EN
  logic timeout_q;

  harness_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk),
    .rst_i    (rst),
    .active_i ((state_q == SEND) || (state_q == RECV)),
    .kick_i   (a_xfer | b_xfer | z_xfer),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst)           timeout_q <= 1'b0;
    else if (start_ok) timeout_q <= 1'b0;
    else if (wd_expire) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = FETCH;
      FETCH:      state_d = WAIT_MEM;
      WAIT_MEM:   state_d = SEND;
      // A stream is finished when its strobe is already down or drops now.
      SEND: begin
        if ((!a_stb_q || a_xfer) && (!b_stb_q || b_xfer)) state_d = RECV;
        else if (wd_expire)                               state_d = DONE;
      end
      RECV: begin
        if (z_xfer)         state_d = CHECK;
        else if (wd_expire) state_d = DONE;
      end
      CHECK:      state_d = (index_q == LAST_IDX) ? DONE : FETCH;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE) && (state_q != DONE);
    done        = (state_q == DONE);
    pass        = done && (err_q == '0) && !timeout;
    input_z_ack = (state_q == RECV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_exp_q <= '0;
      z_got_q <= '0;
      a_stb_q <= 1'b0;
      b_stb_q <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      if (start_ok) begin
        index_q <= '0;
        err_q   <= '0;
        first_q <= '0;
      end
      if (state_q == WAIT_MEM) begin
        a_q     <= vec_a;
        b_q     <= vec_b;
        z_exp_q <= vec_z;
        a_stb_q <= 1'b1;
        b_stb_q <= 1'b1;
      end
      if (a_xfer || wd_expire) a_stb_q <= 1'b0;
      if (b_xfer || wd_expire) b_stb_q <= 1'b0;
      if (z_xfer) z_got_q <= input_z;
      if (err_evt) begin
        err_q <= sat_inc(err_q);
        if (err_q == '0) first_q <= index_q;
      end
      if ((state_q == CHECK) && (index_q != LAST_IDX)) index_q <= index_q + 1'b1;
    end
  end

  assign vec_addr     = index_q;
  assign output_a     = a_q;
  assign output_b     = b_q;
  assign output_a_stb = a_stb_q;
  assign output_b_stb = b_stb_q;
  assign error_count  = err_q;
  assign first_fail   = first_q;

endmodule

// File: tb/tb_fpu_vector_harness.sv
// tb_fpu_vector_harness
// Self-checking bench for fpu_vector_harness (DEPTH=4, TIMEOUT=16).
// Operand transfers are checked against a scoreboard queue filled when a run
// is started; run results are checked against a table of expected outcomes.
module tb_fpu_vector_harness;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int TO    = 16;

  logic             clk, rst, start;
  logic [AW-1:0]    vec_addr;
  logic [WIDTH-1:0] vec_a, vec_b, vec_z;
  logic [WIDTH-1:0] output_a, output_b, input_z;
  logic             output_a_stb, output_a_ack, output_b_stb, output_b_ack;
  logic             input_z_stb, input_z_ack;
  logic             busy, done, pass, timeout;
  logic [15:0]      error_count;
  logic [AW-1:0]    first_fail;

  fpu_vector_harness #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_addr(vec_addr), .vec_a(vec_a), .vec_b(vec_b), .vec_z(vec_z),
    .output_a(output_a), .output_a_stb(output_a_stb), .output_a_ack(output_a_ack),
    .output_b(output_b), .output_b_stb(output_b_stb), .output_b_ack(output_b_ack),
    .input_z(input_z), .input_z_stb(input_z_stb), .input_z_ack(input_z_ack),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_fail(first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int na = 0, nb = 0;
  logic z_en;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_z [DEPTH];
  logic [WIDTH-1:0] qa [$];
  logic [WIDTH-1:0] qb [$];

  typedef struct {
    logic [3:0] bad;
    int         exp_err;
    int         exp_first;
    logic       exp_pass;
  } run_t;

  run_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] fmodel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + b;
  endfunction

  // synchronous vector memory, one cycle read latency
  always @(posedge clk) begin
    vec_a <= mem_a[vec_addr[1:0]];
    vec_b <= mem_b[vec_addr[1:0]];
    vec_z <= mem_z[vec_addr[1:0]];
  end

  // scoreboard: every operand transfer must match the next queued vector
  always @(negedge clk) begin
    if (!rst) begin
      if (output_a_stb && output_a_ack) begin
        na++;
        chk("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) chk("a_stream", output_a, qa.pop_front());
      end
      if (output_b_stb && output_b_ack) begin
        nb++;
        chk("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) chk("b_stream", output_b, qb.pop_front());
      end
    end
  end

  // FPU model: takes operands, returns the result one cycle after both arrive
  initial begin : fpu_model
    logic r, ax, bx, zx, ga, gb;
    logic [WIDTH-1:0] va, vb, ra, rb;
    ga = 0; gb = 0; ra = '0; rb = '0;
    input_z_stb = 1'b0;
    input_z     = '0;
    forever begin
      @(negedge clk);
      r  = rst;
      ax = output_a_stb & output_a_ack;
      bx = output_b_stb & output_b_ack;
      zx = input_z_stb & input_z_ack;
      va = output_a;
      vb = output_b;
      @(posedge clk);
      #1;
      if (r) begin
        ga = 0; gb = 0; input_z_stb = 1'b0;
      end else begin
        if (zx) input_z_stb = 1'b0;
        if (ax) begin ra = va; ga = 1; end
        if (bx) begin rb = vb; gb = 1; end
        if (ga && gb && z_en) begin
          input_z     = fmodel(ra, rb);
          input_z_stb = 1'b1;
          ga = 0; gb = 0;
        end
      end
    end
  end

  task automatic load_std(input logic [3:0] bad);
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'h3F800000;
      mem_b[i] = 32'h40000000;
      mem_z[i] = bad[i] ? 32'h40400001 : 32'h40400000;
    end
  endtask

  task automatic load_distinct();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'h1000_0000 + 32'(i * 3);
      mem_b[i] = 32'h0000_0100 * 32'(i + 1);
      mem_z[i] = mem_a[i] + mem_b[i];
    end
  endtask

  task automatic push_sb();
    for (int i = 0; i < DEPTH; i++) begin
      qa.push_back(mem_a[i]);
      qb.push_back(mem_b[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!done && n < lim) begin @(posedge clk); #1; n++; end
    chk("done_within_bound", 32'(done), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  initial begin : fail_safe
    #200000;
    $display("FAIL global_time_limit: actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin : main
    int n, k;
    rst = 1'b1; start = 1'b0; z_en = 1'b1;
    output_a_ack = 1'b1; output_b_ack = 1'b1;
    load_std(4'b0000);
    cycles(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_err", 32'(error_count), 0);
    chk("rst_first", 32'(first_fail), 0);
    chk("rst_addr", 32'(vec_addr), 0);
    chk("rst_a_stb", 32'(output_a_stb), 0);
    chk("rst_b_stb", 32'(output_b_stb), 0);
    chk("rst_z_ack", 32'(input_z_ack), 0);
    rst = 1'b0;
    cycles(1);

    tbl = '{'{4'b0000, 0, 0, 1'b1},
            '{4'b0100, 1, 2, 1'b0},
            '{4'b1001, 2, 0, 1'b0},
            '{4'b1111, 4, 0, 1'b0},
            '{4'b1000, 1, 3, 1'b0}};

    foreach (tbl[t]) begin
      load_std(tbl[t].bad);
      push_sb();
      pulse_start();
      wait_done(40, n);
      chk($sformatf("run%0d_cycles", t), 32'(n), 32'd20);
      chk($sformatf("run%0d_err", t), 32'(error_count), 32'(tbl[t].exp_err));
      chk($sformatf("run%0d_first", t), 32'(first_fail), 32'(tbl[t].exp_first));
      chk($sformatf("run%0d_pass", t), 32'(pass), 32'(tbl[t].exp_pass));
      chk($sformatf("run%0d_busy", t), 32'(busy), 0);
      chk($sformatf("run%0d_timeout", t), 32'(timeout), 0);
      chk($sformatf("run%0d_sb_empty", t), 32'(qa.size() + qb.size()), 0);
      cycles(2);
      chk($sformatf("run%0d_done_held", t), 32'(done), 1);
    end

    // staggered operand acks
    load_std(4'b0000);
    push_sb();
    output_a_ack = 1'b0; output_b_ack = 1'b0;
    pulse_start();
    k = 0;
    while (!output_a_stb && k < 10) begin @(posedge clk); #1; k++; end
    chk("send_reached", 32'(output_a_stb), 1);
    na = 0; nb = 0;
    output_a_ack = 1'b1;
    cycles(1);
    output_a_ack = 1'b0;
    chk("stag_a_dropped", 32'(output_a_stb), 0);
    chk("stag_b_held_c2", 32'(output_b_stb), 1);
    cycles(2);
    chk("stag_a_low_c4", 32'(output_a_stb), 0);
    chk("stag_b_held_c4", 32'(output_b_stb), 1);
    cycles(1);
    chk("stag_no_recv_c5", 32'(input_z_ack), 0);
    output_b_ack = 1'b1;
    cycles(1);
    output_b_ack = 1'b0;
    chk("stag_b_dropped", 32'(output_b_stb), 0);
    chk("stag_recv_c6", 32'(input_z_ack), 1);
    chk("stag_a_count", 32'(na), 1);
    chk("stag_b_count", 32'(nb), 1);
    output_a_ack = 1'b1; output_b_ack = 1'b1;
    wait_done(60, n);
    chk("stag_pass", 32'(pass), 1);
    chk("stag_sb_empty", 32'(qa.size() + qb.size()), 0);

    // start while busy is ignored
    load_std(4'b0001);
    push_sb();
    pulse_start();
    k = 0;
    while (vec_addr != 2 && k < 30) begin @(posedge clk); #1; k++; end
    chk("busy_start_addr_pre", 32'(vec_addr), 2);
    pulse_start();
    chk("busy_start_addr", 32'(vec_addr), 2);
    chk("busy_start_err", 32'(error_count), 1);
    chk("busy_start_busy", 32'(busy), 1);
    wait_done(40, n);
    chk("busy_start_final_err", 32'(error_count), 1);
    chk("busy_start_first", 32'(first_fail), 0);
    chk("busy_start_pass", 32'(pass), 0);
    chk("busy_start_sb_empty", 32'(qa.size() + qb.size()), 0);

    // result never arrives
    load_std(4'b0000);
    push_sb();
    z_en = 1'b0;
    pulse_start();
    k = 0;
    while (!input_z_ack && k < 20) begin @(posedge clk); #1; k++; end
    chk("stall_recv_reached", 32'(input_z_ack), 1);
`ifdef HARNESS_TIMEOUT_EN
    cycles(TO - 1);
    chk("wd_not_yet", 32'(done), 0);
    cycles(1);
    chk("wd_done", 32'(done), 1);
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_err", 32'(error_count), 1);
    chk("wd_first", 32'(first_fail), 0);
    chk("wd_pass", 32'(pass), 0);
`else
    cycles(40);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_done", 32'(done), 0);
    chk("stall_timeout", 32'(timeout), 0);
    chk("stall_recv_held", 32'(input_z_ack), 1);
`endif
    z_en = 1'b1;
    reset_pulse();
    cycles(1);

    // reset while waiting in RECV, then a clean rerun from index 0
    load_std(4'b0001);
    push_sb();
    pulse_start();
    k = 0;
    while (vec_addr != 1 && k < 30) begin @(posedge clk); #1; k++; end
    z_en = 1'b0;
    k = 0;
    while (!input_z_ack && k < 20) begin @(posedge clk); #1; k++; end
    chk("abort_in_recv", 32'(input_z_ack), 1);
    chk("abort_err_pre", 32'(error_count), 1);
    rst = 1'b1;
    cycles(1);
    chk("abort_a_stb", 32'(output_a_stb), 0);
    chk("abort_b_stb", 32'(output_b_stb), 0);
    chk("abort_z_ack", 32'(input_z_ack), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_err", 32'(error_count), 0);
    chk("abort_first", 32'(first_fail), 0);
    chk("abort_addr", 32'(vec_addr), 0);
    rst = 1'b0;
    qa.delete(); qb.delete();
    z_en = 1'b1;
    na = 0; nb = 0;
    cycles(3);
    chk("abort_no_xfer", 32'(na + nb), 0);
    load_distinct();
    push_sb();
    pulse_start();
    wait_done(40, n);
    chk("rerun_cycles", 32'(n), 32'd20);
    chk("rerun_pass", 32'(pass), 1);
    chk("rerun_err", 32'(error_count), 0);
    chk("rerun_sb_empty", 32'(qa.size() + qb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
